mc_control_fsm: RTL and testbench

Multicycle control unit that drives the ALU's control inputs (4-bit op code, shamt, 16-bit immediate) and the surrounding register-file and data-memory strobes. It accepts one 32-bit MIPS instruction per handshake, decodes it, sequences it through execute, memory and writeback states, and samples the ALU zero flag to resolve branches. It sits between instruction fetch and the ALU/register-file datapath.

---
 rtl/mc_control_fsm_pkg.sv | 74 +++++++
 rtl/mc_control_fsm_alu_op_decode.sv | 101 ++++++++++
 rtl/mc_control_fsm.sv | 200 ++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multicycle MIPS control unit (package mips_ctrl_pkg).
// Contents: primary opcode and R-type funct constants, the 4-bit ALU
// op-code encoding, the control FSM state enum and the instruction class
// enum produced by the decoder.
package mips_ctrl_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // ALU op-code encoding
  localparam logic [3:0] ALU_SLL  = 4'b0000;
  localparam logic [3:0] ALU_SRL  = 4'b0001;
  localparam logic [3:0] ALU_SRA  = 4'b0010;
  localparam logic [3:0] ALU_SLLV = 4'b0011;
  localparam logic [3:0] ALU_SRLV = 4'b0100;
  localparam logic [3:0] ALU_SRAV = 4'b0101;
  localparam logic [3:0] ALU_ADD  = 4'b0110;
  localparam logic [3:0] ALU_SUB  = 4'b0111;
  localparam logic [3:0] ALU_AND  = 4'b1000;
  localparam logic [3:0] ALU_OR   = 4'b1001;
  localparam logic [3:0] ALU_XOR  = 4'b1010;
  localparam logic [3:0] ALU_NOR  = 4'b1011;
  localparam logic [3:0] ALU_SLT  = 4'b1100;
  localparam logic [3:0] ALU_SLTU = 4'b1101;
  localparam logic [3:0] ALU_LUI  = 4'b1110;
  localparam logic [3:0] ALU_ORI  = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BEQ,
    CLS_BNE
  } instr_class_t;

endpackage

// File: rtl/mc_control_fsm_alu_op_decode.sv
// alu_op_decode: purely combinational instruction decoder.
// Ports:
//   opcode, funct  in   instruction fields instr[31:26], instr[5:0]
//   alu_op         out  4-bit ALU op code
//   src_imm        out  ALU In2 takes the extended immediate
//   zext           out  immediate is zero-extended (0 = sign-extended)
//   wr_en          out  instruction writes the register file
//   dst_rt         out  destination is rt (I-type) rather than rd (R-type)
//   cls            out  instruction class for sequencing
//   illegal        out  opcode/funct not decodable
// Build option: define VAR_SHIFT_EN to accept sllv/srlv/srav.
module alu_op_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output logic [3:0]   alu_op,
  output logic         src_imm,
  output logic         zext,
  output logic         wr_en,
  output logic         dst_rt,
  output instr_class_t cls,
  output logic         illegal
);

  always_comb begin
    alu_op  = ALU_ADD;
    src_imm = 1'b0;
    zext    = 1'b0;
    wr_en   = 1'b0;
    dst_rt  = 1'b0;
    cls     = CLS_ALU;
    illegal = 1'b0;

    case (opcode)
      OP_RTYPE: begin
        wr_en = 1'b1;
        case (funct)
          FN_SLL:          alu_op = ALU_SLL;
          FN_SRL:          alu_op = ALU_SRL;
          FN_SRA:          alu_op = ALU_SRA;
`ifdef VAR_SHIFT_EN
          FN_SLLV:         alu_op = ALU_SLLV;
          FN_SRLV:         alu_op = ALU_SRLV;
          FN_SRAV:         alu_op = ALU_SRAV;
`endif
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_AND:          alu_op = ALU_AND;
          FN_OR:           alu_op = ALU_OR;
          FN_XOR:          alu_op = ALU_XOR;
          FN_NOR:          alu_op = ALU_NOR;
          FN_SLT:          alu_op = ALU_SLT;
          FN_SLTU:         alu_op = ALU_SLTU;
          default:         illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        alu_op = ALU_ADD;  src_imm = 1'b1; wr_en = 1'b1; dst_rt = 1'b1;
      end
      OP_SLTI: begin
        alu_op = ALU_SLT;  src_imm = 1'b1; wr_en = 1'b1; dst_rt = 1'b1;
      end
      OP_SLTIU: begin
        alu_op = ALU_SLTU; src_imm = 1'b1; wr_en = 1'b1; dst_rt = 1'b1;
      end
      OP_ANDI: begin
        alu_op = ALU_AND;  src_imm = 1'b1; zext = 1'b1; wr_en = 1'b1; dst_rt = 1'b1;
      end
      OP_XORI: begin
        alu_op = ALU_XOR;  src_imm = 1'b1; zext = 1'b1; wr_en = 1'b1; dst_rt = 1'b1;
      end
      OP_ORI: begin
        alu_op = ALU_ORI;  src_imm = 1'b1; zext = 1'b1; wr_en = 1'b1; dst_rt = 1'b1;
      end
      // lui only uses the low 16 immediate bits, so extension is moot;
      // flag it zero-extended like the other logical immediates.
      OP_LUI: begin
        alu_op = ALU_LUI;  src_imm = 1'b1; zext = 1'b1; wr_en = 1'b1; dst_rt = 1'b1;
      end
      OP_LW: begin
        alu_op = ALU_ADD;  src_imm = 1'b1; wr_en = 1'b1; dst_rt = 1'b1; cls = CLS_LOAD;
      end
      OP_SW: begin
        alu_op = ALU_ADD;  src_imm = 1'b1; dst_rt = 1'b1; cls = CLS_STORE;
      end
      OP_BEQ: begin
        alu_op = ALU_SUB;  dst_rt = 1'b1; cls = CLS_BEQ;
      end
      OP_BNE: begin
        alu_op = ALU_SUB;  dst_rt = 1'b1; cls = CLS_BNE;
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      wr_en = 1'b0;
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle control unit for a MIPS-style ALU datapath.
// Accepts one instruction per instr_valid/instr_ready handshake and
// sequences it IDLE -> DECODE -> EXEC -> (MEM) -> (WB) -> IDLE.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   instr_valid/instr_ready    instruction handshake (ready only in IDLE)
//   instr                      32-bit instruction word
//   alu_op/alu_shamt/alu_imm   ALU controls, held from DECODE until next accept
//   alu_src_imm, imm_zext      ALU In2 select and immediate extension
//   rs_addr, rt_addr           register-file read addresses
//   zero_flag                  ALU zero flag, sampled in EXEC for branches
//   reg_we, reg_waddr          one-cycle register write strobe and address
//   mem_req, mem_we, mem_ack   data-memory handshake (req held until ack)
//   branch_taken, done         one-cycle pulses in WB
//   illegal                    one-cycle pulse: undecodable or memory timeout
// Parameter MEM_TIMEOUT: max MEM cycles without mem_ack (0 = no timeout).
// Build option: define VAR_SHIFT_EN to accept sllv/srlv/srav.
module mc_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [3:0]  alu_op,
  output logic [4:0]  alu_shamt,
  output logic [15:0] alu_imm,
  output logic        alu_src_imm,
  output logic        imm_zext,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  input  logic        zero_flag,
  output logic        reg_we,
  output logic [4:0]  reg_waddr,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        branch_taken,
  output logic        done,
  output logic        illegal
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t          state;
  logic [31:0]     ir;
  instr_class_t    cls_q;
  logic            wr_q;
  logic [CNT_W-1:0] mem_cnt;

  logic [3:0]      dec_alu_op;
  logic            dec_src_imm;
  logic            dec_zext;
  logic            dec_wr_en;
  logic            dec_dst_rt;
  instr_class_t    dec_cls;
  logic            dec_illegal;
  logic [4:0]      dec_waddr;

  alu_op_decode u_dec (
    .opcode  (ir[31:26]),
    .funct   (ir[5:0]),
    .alu_op  (dec_alu_op),
    .src_imm (dec_src_imm),
    .zext    (dec_zext),
    .wr_en   (dec_wr_en),
    .dst_rt  (dec_dst_rt),
    .cls     (dec_cls),
    .illegal (dec_illegal)
  );

  assign dec_waddr = dec_dst_rt ? ir[20:16] : ir[15:11];

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      ir           <= '0;
      cls_q        <= CLS_ALU;
      wr_q         <= 1'b0;
      mem_cnt      <= '0;
      instr_ready  <= 1'b1;
      alu_op       <= '0;
      alu_shamt    <= '0;
      alu_imm      <= '0;
      alu_src_imm  <= 1'b0;
      imm_zext     <= 1'b0;
      rs_addr      <= '0;
      rt_addr      <= '0;
      reg_we       <= 1'b0;
      reg_waddr    <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      branch_taken <= 1'b0;
      done         <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      // Pulse outputs are asserted on the edge entering the cycle in which
      // they are visible, so each one defaults low every cycle.
      reg_we       <= 1'b0;
      branch_taken <= 1'b0;
      done         <= 1'b0;
      illegal      <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (instr_valid && instr_ready) begin
            ir          <= instr;
            instr_ready <= 1'b0;
            state       <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          alu_op      <= dec_alu_op;
          alu_shamt   <= ir[10:6];
          alu_imm     <= ir[15:0];
          alu_src_imm <= dec_src_imm;
          imm_zext    <= dec_zext;
          rs_addr     <= ir[25:21];
          rt_addr     <= ir[20:16];
          reg_waddr   <= dec_waddr;
          cls_q       <= dec_cls;
          // Writes to $0 are suppressed here so WB never strobes reg_we for them.
          wr_q        <= dec_wr_en && (dec_waddr != 5'd0);
          if (dec_illegal) begin
            illegal     <= 1'b1;
            instr_ready <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            state <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          case (cls_q)
            CLS_LOAD, CLS_STORE: begin
              mem_req <= 1'b1;
              mem_we  <= (cls_q == CLS_STORE);
              mem_cnt <= '0;
              state   <= ST_MEM;
            end
            CLS_BEQ: begin
              branch_taken <= zero_flag;
              done         <= 1'b1;
              state        <= ST_WB;
            end
            CLS_BNE: begin
              branch_taken <= !zero_flag;
              done         <= 1'b1;
              state        <= ST_WB;
            end
            default: begin
              reg_we <= wr_q;
              done   <= 1'b1;
              state  <= ST_WB;
            end
          endcase
        end

        ST_MEM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            if (cls_q == CLS_LOAD) begin
              reg_we <= wr_q;
              state  <= ST_WB;
            end else begin
              instr_ready <= 1'b1;
              state       <= ST_IDLE;
            end
          end else if ((MEM_TIMEOUT != 0) && (mem_cnt == CNT_LAST)) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            illegal     <= 1'b1;
            instr_ready <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            mem_cnt <= mem_cnt + 1'b1;
          end
        end

        ST_WB: begin
          instr_ready <= 1'b1;
          state       <= ST_IDLE;
        end

        default: begin
          instr_ready <= 1'b1;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [3:0]  alu_op;
  logic [4:0]  alu_shamt;
  logic [15:0] alu_imm;
  logic        alu_src_imm;
  logic        imm_zext;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        zero_flag;
  logic        reg_we;
  logic [4:0]  reg_waddr;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ack;
  logic        branch_taken;
  logic        done;
  logic        illegal;

  mc_control_fsm #(.MEM_TIMEOUT(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .alu_op       (alu_op),
    .alu_shamt    (alu_shamt),
    .alu_imm      (alu_imm),
    .alu_src_imm  (alu_src_imm),
    .imm_zext     (imm_zext),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .zero_flag    (zero_flag),
    .reg_we       (reg_we),
    .reg_waddr    (reg_waddr),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_ack      (mem_ack),
    .branch_taken (branch_taken),
    .done         (done),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer an instruction; returns in cycle N+1 (DECODE) after accept edge N.
  task automatic issue(input logic [31:0] w);
    instr       = w;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    logic        ill;
    logic [3:0]  op;
    logic        src;
    logic        zext;
    logic        zext_chk;
    logic [4:0]  waddr;
    logic        we;
    logic        br;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] w;
    w = v.instr;
    issue(w);
    chk($sformatf("v%0d_ready_n1", idx), {31'd0, instr_ready}, 32'd0);
    tick(); // N+2
    if (v.ill) begin
      chk($sformatf("v%0d_illegal_n2", idx), {31'd0, illegal}, 32'd1);
      chk($sformatf("v%0d_done_n2", idx), {31'd0, done}, 32'd0);
    end else begin
      chk($sformatf("v%0d_illegal_n2", idx), {31'd0, illegal}, 32'd0);
      chk($sformatf("v%0d_op", idx), {28'd0, alu_op}, {28'd0, v.op});
      chk($sformatf("v%0d_imm", idx), {16'd0, alu_imm}, {16'd0, w[15:0]});
      chk($sformatf("v%0d_shamt", idx), {27'd0, alu_shamt}, {27'd0, w[10:6]});
      chk($sformatf("v%0d_src", idx), {31'd0, alu_src_imm}, {31'd0, v.src});
      if (v.zext_chk)
        chk($sformatf("v%0d_zext", idx), {31'd0, imm_zext}, {31'd0, v.zext});
      chk($sformatf("v%0d_rs", idx), {27'd0, rs_addr}, {27'd0, w[25:21]});
      chk($sformatf("v%0d_rt", idx), {27'd0, rt_addr}, {27'd0, w[20:16]});
      chk($sformatf("v%0d_waddr", idx), {27'd0, reg_waddr}, {27'd0, v.waddr});
      chk($sformatf("v%0d_we_n2", idx), {31'd0, reg_we}, 32'd0);
    end
    zero_flag = v.zero;
    tick(); // N+3
    chk($sformatf("v%0d_we_n3", idx), {31'd0, reg_we}, {31'd0, v.we});
    chk($sformatf("v%0d_done_n3", idx), {31'd0, done}, {31'd0, !v.ill});
    chk($sformatf("v%0d_br_n3", idx), {31'd0, branch_taken}, {31'd0, v.br});
    chk($sformatf("v%0d_illegal_n3", idx), {31'd0, illegal}, 32'd0);
    zero_flag = 1'b0;
    tick(); // N+4
    chk($sformatf("v%0d_ready_n4", idx), {31'd0, instr_ready}, 32'd1);
    chk($sformatf("v%0d_done_n4", idx), {31'd0, done}, 32'd0);
  endtask

  initial begin
    //            instr         z  ill  op     src  zx  zchk wa   we  br
    vecs[0]  = '{32'h00221820, 0, 0, 4'b0110, 0, 0, 1, 5'd3,  1, 0}; // add $3,$1,$2
    vecs[1]  = '{32'h340500FF, 0, 0, 4'b1111, 1, 1, 1, 5'd5,  1, 0}; // ori $5,$0,0xFF
    vecs[2]  = '{32'h3C041234, 0, 0, 4'b1110, 1, 0, 0, 5'd4,  1, 0}; // lui $4,0x1234
    vecs[3]  = '{32'h10220004, 1, 0, 4'b0111, 0, 0, 1, 5'd2,  0, 1}; // beq, zero=1
    vecs[4]  = '{32'h14220004, 1, 0, 4'b0111, 0, 0, 1, 5'd2,  0, 0}; // bne, zero=1
    vecs[5]  = '{32'h14220004, 0, 0, 4'b0111, 0, 0, 1, 5'd2,  0, 1}; // bne, zero=0
    vecs[6]  = '{32'h10220004, 0, 0, 4'b0111, 0, 0, 1, 5'd2,  0, 0}; // beq, zero=0
    vecs[7]  = '{32'h00220020, 0, 0, 4'b0110, 0, 0, 1, 5'd0,  0, 0}; // add $0 (no write)
    vecs[8]  = '{32'h00223822, 0, 0, 4'b0111, 0, 0, 1, 5'd7,  1, 0}; // sub $7
    vecs[9]  = '{32'h00024103, 0, 0, 4'b0010, 0, 0, 1, 5'd8,  1, 0}; // sra $8,$2,4
    vecs[10] = '{32'h2829FFFF, 0, 0, 4'b1100, 1, 0, 1, 5'd9,  1, 0}; // slti $9,$1,-1
    vecs[11] = '{32'h302A8000, 0, 0, 4'b1000, 1, 1, 1, 5'd10, 1, 0}; // andi $10
    vecs[12] = '{32'h382B0F0F, 0, 0, 4'b1010, 1, 1, 1, 5'd11, 1, 0}; // xori $11
    vecs[13] = '{32'h00226027, 0, 0, 4'b1011, 0, 0, 1, 5'd12, 1, 0}; // nor $12
    vecs[14] = '{32'hFC000000, 0, 1, 4'b0000, 0, 0, 0, 5'd0,  0, 0}; // opcode 0x3F
`ifdef VAR_SHIFT_EN
    vecs[15] = '{32'h00221804, 0, 0, 4'b0011, 0, 0, 1, 5'd3,  1, 0}; // sllv
`else
    vecs[15] = '{32'h00221804, 0, 1, 4'b0000, 0, 0, 0, 5'd0,  0, 0}; // sllv disabled
`endif
    vecs[16] = '{32'h00221801, 0, 1, 4'b0000, 0, 0, 0, 5'd0,  0, 0}; // funct 0x01
    vecs[17] = '{32'h240D0005, 0, 0, 4'b0110, 1, 0, 1, 5'd13, 1, 0}; // addiu $13
    vecs[18] = '{32'h0022182B, 0, 0, 4'b1101, 0, 0, 1, 5'd3,  1, 0}; // sltu $3

    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    zero_flag   = 1'b0;
    mem_ack     = 1'b0;
    tick();
    tick();
    chk("rst_ready",   {31'd0, instr_ready}, 32'd1);
    chk("rst_alu_op",  {28'd0, alu_op}, 32'd0);
    chk("rst_imm",     {16'd0, alu_imm}, 32'd0);
    chk("rst_reg_we",  {31'd0, reg_we}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_done",    {31'd0, done}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_branch",  {31'd0, branch_taken}, 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], i);
    end

    // lw $6,8($1): ack delayed 3 cycles, plus a stray ack during EXEC.
    issue(32'h8C260008);                       // N+1
    tick();                                    // N+2 EXEC
    chk("lw_op", {28'd0, alu_op}, 32'd6);
    chk("lw_req_exec", {31'd0, mem_req}, 32'd0);
    mem_ack = 1'b1;                            // sampled in EXEC: ignored
    tick();                                    // N+3 MEM
    mem_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin          // N+3..N+6
      chk($sformatf("lw_req_c%0d", c), {31'd0, mem_req}, 32'd1);
      chk($sformatf("lw_we_c%0d", c), {31'd0, reg_we}, 32'd0);
      if (c == 3) mem_ack = 1'b1;
      if (c == 0) chk("lw_mem_we", {31'd0, mem_we}, 32'd0);
      tick();
    end
    mem_ack = 1'b0;                            // N+7 WB
    chk("lw_req_wb", {31'd0, mem_req}, 32'd0);
    chk("lw_reg_we", {31'd0, reg_we}, 32'd1);
    chk("lw_done",   {31'd0, done}, 32'd1);
    chk("lw_waddr",  {27'd0, reg_waddr}, 32'd6);
    tick();                                    // N+8
    chk("lw_ready", {31'd0, instr_ready}, 32'd1);
    chk("lw_we_off", {31'd0, reg_we}, 32'd0);

    // lw minimum latency: ack on the first MEM cycle.
    issue(32'h8C260008);
    tick();                                    // N+2
    tick();                                    // N+3 MEM
    mem_ack = 1'b1;
    tick();                                    // N+4 WB
    mem_ack = 1'b0;
    chk("lwmin_reg_we", {31'd0, reg_we}, 32'd1);
    chk("lwmin_req", {31'd0, mem_req}, 32'd0);
    tick();                                    // N+5
    chk("lwmin_ready", {31'd0, instr_ready}, 32'd1);

    // sw $2,0($1) with ack on second MEM cycle.
    issue(32'hAC220000);
    tick();                                    // N+2
    tick();                                    // N+3 MEM
    chk("sw_req", {31'd0, mem_req}, 32'd1);
    chk("sw_mem_we", {31'd0, mem_we}, 32'd1);
    tick();                                    // N+4
    mem_ack = 1'b1;
    tick();                                    // N+5 IDLE
    mem_ack = 1'b0;
    chk("sw_done", {31'd0, done}, 32'd1);
    chk("sw_reg_we", {31'd0, reg_we}, 32'd0);
    chk("sw_req_off", {31'd0, mem_req}, 32'd0);
    chk("sw_ready", {31'd0, instr_ready}, 32'd1);
    tick();

    // sw with no ack: 16 MEM cycles, then illegal.
    issue(32'hAC220000);
    tick();                                    // N+2
    tick();                                    // N+3
    for (int c = 0; c < 16; c++) begin         // N+3..N+18
      chk($sformatf("to_req_c%0d", c), {31'd0, mem_req}, 32'd1);
      chk($sformatf("to_ill_c%0d", c), {31'd0, illegal}, 32'd0);
      tick();
    end
    chk("to_illegal", {31'd0, illegal}, 32'd1); // N+19
    chk("to_req_off", {31'd0, mem_req}, 32'd0);
    chk("to_done",    {31'd0, done}, 32'd0);
    chk("to_ready",   {31'd0, instr_ready}, 32'd1);
    tick();
    chk("to_ill_off", {31'd0, illegal}, 32'd0);

    // Reset during MEM aborts the load.
    issue(32'h8C260008);
    tick();                                    // N+2
    tick();                                    // N+3 MEM
    chk("rm_req", {31'd0, mem_req}, 32'd1);
    tick();                                    // N+4 MEM
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rm_req_off", {31'd0, mem_req}, 32'd0);
    chk("rm_ready",   {31'd0, instr_ready}, 32'd1);
    chk("rm_reg_we",  {31'd0, reg_we}, 32'd0);
    chk("rm_done",    {31'd0, done}, 32'd0);
    tick();
    chk("rm_done2",   {31'd0, done}, 32'd0);
    chk("rm_req2",    {31'd0, mem_req}, 32'd0);

    // Recovery after abort.
    run_vec(vecs[0], 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
